// File: rtl/bmp_pixel_unpack_if.sv
// Stream interface of the BMP pixel unpacker: SD read words in, RGB565 pixels out.
// The master drives start/in_valid/in_data; the slave (the unpacker) drives everything else.
interface bmp_pixel_unpack_if #(
  parameter int unsigned ADDR_W = 20
) ();
  logic              start;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              pix_valid;
  logic [15:0]       pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_last;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, in_data,
    input  pix_valid, pix_data, pix_addr, pix_last, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output pix_valid, pix_data, pix_addr, pix_last, busy, done
  );
endinterface

// File: rtl/bmp_pixel_unpack.sv
// Parses a 24-bit bottom-up BMP byte stream (two bytes per word) into RGB565 pixels
// with top-down raster addresses, skipping the file header and per-row padding.
module bmp_pixel_unpack #(
  parameter int unsigned HDR_BYTES = 54,
  parameter int unsigned IMG_W     = 1024,
  parameter int unsigned IMG_H     = 768,
  parameter int unsigned ADDR_W    = 20
) (
  input logic               clk,
  input logic               rst,
  bmp_pixel_unpack_if.slave bus
);

  localparam int unsigned Stride = ((IMG_W * 3 + 3) / 4) * 4;
  localparam int unsigned Pad    = Stride - IMG_W * 3;
  localparam int unsigned HdrW   = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam int unsigned XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [HdrW-1:0]   HdrLast  = HdrW'(HDR_BYTES - 1);
  localparam logic [XW-1:0]     XLast    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     YLast    = YW'(IMG_H - 1);
  localparam logic [1:0]        PadLast  = 2'(Pad - 1);
  localparam logic [ADDR_W-1:0] RowBase0 = ADDR_W'((IMG_H - 1) * IMG_W);
  localparam logic [ADDR_W-1:0] RowStep  = ADDR_W'(IMG_W);

  typedef enum logic [2:0] {StIdle, StHeader, StPixel, StPad, StDone} state_e;

  state_e              state_q, state_d;
  logic [HdrW-1:0]     hdr_cnt_q, hdr_cnt_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [4:0]          b_q, b_d;
  logic [5:0]          g_q, g_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [1:0]          pad_cnt_q, pad_cnt_d;

  logic                pix_valid_q, pix_valid_d;
  logic [15:0]         pix_data_q, pix_data_d;
  logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
  logic                pix_last_q, pix_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [7:0]          byt;
  logic                unused_byt_bits;

  assign unused_byt_bits = ^byt[1:0];

  // Both bytes of a word are walked in order; the second byte sees the state left by the first.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    bidx_d      = bidx_q;
    b_d         = b_q;
    g_d         = g_q;
    x_d         = x_q;
    y_d         = y_q;
    row_base_d  = row_base_q;
    pad_cnt_d   = pad_cnt_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    pix_addr_d  = pix_addr_q;
    pix_last_d  = pix_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    byt         = 8'h00;

    if (bus.start) begin
      state_d    = (HDR_BYTES == 0) ? StPixel : StHeader;
      hdr_cnt_d  = '0;
      bidx_d     = '0;
      b_d        = '0;
      g_d        = '0;
      x_d        = '0;
      y_d        = '0;
      row_base_d = RowBase0;
      pad_cnt_d  = '0;
      busy_d     = 1'b1;
    end else if (bus.in_valid) begin
      for (int i = 0; i < 2; i++) begin
        byt = (i == 0) ? bus.in_data[15:8] : bus.in_data[7:0];
        case (state_d)
          StHeader: begin
            if (hdr_cnt_d == HdrLast) begin
              state_d = StPixel;
            end else begin
              hdr_cnt_d = hdr_cnt_d + 1'b1;
            end
          end
          StPixel: begin
            if (bidx_d == 2'd0) begin
              b_d    = byt[7:3];
              bidx_d = 2'd1;
            end else if (bidx_d == 2'd1) begin
              g_d    = byt[7:2];
              bidx_d = 2'd2;
            end else begin
              bidx_d      = 2'd0;
              pix_valid_d = 1'b1;
              pix_data_d  = {byt[7:3], g_d, b_d};
              pix_addr_d  = row_base_d + ADDR_W'(x_d);
              pix_last_d  = (x_d == XLast) && (y_d == YLast);
              if (x_d == XLast) begin
                x_d = '0;
                if (Pad != 0) begin
                  state_d   = StPad;
                  pad_cnt_d = '0;
                end else if (y_d == YLast) begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                end else begin
                  y_d        = y_d + 1'b1;
                  row_base_d = row_base_d - RowStep;
                end
              end else begin
                x_d = x_d + 1'b1;
              end
            end
          end
          StPad: begin
            if (pad_cnt_d == PadLast) begin
              if (y_d == YLast) begin
                state_d = StDone;
                done_d  = 1'b1;
                busy_d  = 1'b0;
              end else begin
                state_d    = StPixel;
                y_d        = y_d + 1'b1;
                row_base_d = row_base_d - RowStep;
              end
            end else begin
              pad_cnt_d = pad_cnt_d + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hdr_cnt_q   <= '0;
      bidx_q      <= '0;
      b_q         <= '0;
      g_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_base_q  <= '0;
      pad_cnt_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_addr_q  <= '0;
      pix_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      bidx_q      <= bidx_d;
      b_q         <= b_d;
      g_q         <= g_d;
      x_q         <= x_d;
      y_q         <= y_d;
      row_base_q  <= row_base_d;
      pad_cnt_q   <= pad_cnt_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_addr_q  <= pix_addr_d;
      pix_last_q  <= pix_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.pix_addr  = pix_addr_q;
  assign bus.pix_last  = pix_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_bmp_pixel_unpack.sv
// Bench for bmp_pixel_unpack: five differently-sized instances fed random BMP byte streams,
// each output cycle compared against expectations derived from file byte offsets.
module tb_bmp_pixel_unpack;

  localparam int NDUT = 5;
  localparam int AW   = 20;

  logic            clk = 1'b0;
  logic [NDUT-1:0] rst;
  int              checks = 0;
  int              errors = 0;

  logic [15:0]     hold_data [NDUT];
  logic [AW-1:0]   hold_addr [NDUT];
  logic            hold_last [NDUT];

  always #5 clk = ~clk;

  bmp_pixel_unpack_if #(.ADDR_W(AW)) if0 ();
  bmp_pixel_unpack_if #(.ADDR_W(AW)) if1 ();
  bmp_pixel_unpack_if #(.ADDR_W(AW)) if2 ();
  bmp_pixel_unpack_if #(.ADDR_W(AW)) if3 ();
  bmp_pixel_unpack_if #(.ADDR_W(AW)) if4 ();

  bmp_pixel_unpack #(.HDR_BYTES(54), .IMG_W(2), .IMG_H(2), .ADDR_W(AW))
    u0 (.clk(clk), .rst(rst[0]), .bus(if0.slave));
  bmp_pixel_unpack #(.HDR_BYTES(54), .IMG_W(1), .IMG_H(3), .ADDR_W(AW))
    u1 (.clk(clk), .rst(rst[1]), .bus(if1.slave));
  bmp_pixel_unpack #(.HDR_BYTES(1), .IMG_W(2), .IMG_H(1), .ADDR_W(AW))
    u2 (.clk(clk), .rst(rst[2]), .bus(if2.slave));
  bmp_pixel_unpack #(.HDR_BYTES(0), .IMG_W(4), .IMG_H(2), .ADDR_W(AW))
    u3 (.clk(clk), .rst(rst[3]), .bus(if3.slave));
  bmp_pixel_unpack #(.HDR_BYTES(54), .IMG_W(5), .IMG_H(3), .ADDR_W(AW))
    u4 (.clk(clk), .rst(rst[4]), .bus(if4.slave));

  function automatic int cfg_hdr(int sel);
    case (sel)
      2:       return 1;
      3:       return 0;
      default: return 54;
    endcase
  endfunction

  function automatic int cfg_w(int sel);
    case (sel)
      0: return 2;
      1: return 1;
      2: return 2;
      3: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int cfg_h(int sel);
    case (sel)
      0: return 2;
      1: return 3;
      2: return 1;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic drive(input int sel, input logic st, input logic v, input logic [15:0] d);
    case (sel)
      0: begin if0.start = st; if0.in_valid = v; if0.in_data = d; end
      1: begin if1.start = st; if1.in_valid = v; if1.in_data = d; end
      2: begin if2.start = st; if2.in_valid = v; if2.in_data = d; end
      3: begin if3.start = st; if3.in_valid = v; if3.in_data = d; end
      default: begin if4.start = st; if4.in_valid = v; if4.in_data = d; end
    endcase
  endtask

  task automatic sample(input int sel, output logic v, output logic [15:0] d,
                        output logic [AW-1:0] a, output logic l, output logic b,
                        output logic dn);
    case (sel)
      0: begin v = if0.pix_valid; d = if0.pix_data; a = if0.pix_addr; l = if0.pix_last;
               b = if0.busy; dn = if0.done; end
      1: begin v = if1.pix_valid; d = if1.pix_data; a = if1.pix_addr; l = if1.pix_last;
               b = if1.busy; dn = if1.done; end
      2: begin v = if2.pix_valid; d = if2.pix_data; a = if2.pix_addr; l = if2.pix_last;
               b = if2.busy; dn = if2.done; end
      3: begin v = if3.pix_valid; d = if3.pix_data; a = if3.pix_addr; l = if3.pix_last;
               b = if3.busy; dn = if3.done; end
      default: begin v = if4.pix_valid; d = if4.pix_data; a = if4.pix_addr; l = if4.pix_last;
               b = if4.busy; dn = if4.done; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pat: 0 random, 1 colour corner cases in the first two pixels, 2 first word 0xAA11.
  task automatic run_frame(input int sel, input bit do_start, input int pat, input int max_words,
                           output int n_pix, output int n_done, output logic [15:0] pix0,
                           output logic [15:0] pix1, output logic [AW-1:0] addr0);
    int hdr, w, h, stride, total, nwords, nrun, p, rel, r, c, x;
    logic [7:0] f[$];
    logic v, l, b, dn, exp_v, exp_l, exp_b, exp_dn;
    logic [15:0] d, exp_d;
    logic [AW-1:0] a, exp_a;
    hdr    = cfg_hdr(sel);
    w      = cfg_w(sel);
    h      = cfg_h(sel);
    stride = ((w * 3 + 3) / 4) * 4;
    total  = hdr + h * stride;
    nwords = (total + 1) / 2;
    nrun   = (max_words < nwords) ? max_words : nwords;
    n_pix  = 0;
    n_done = 0;
    pix0   = '0;
    pix1   = '0;
    addr0  = '0;
    for (int i = 0; i < nwords * 2; i++) f.push_back(8'($urandom_range(0, 255)));
    if (pat == 1) begin
      f[hdr] = 8'hFF; f[hdr+1] = 8'h00; f[hdr+2] = 8'h80;
      f[hdr+3] = 8'hFF; f[hdr+4] = 8'hFF; f[hdr+5] = 8'hFF;
    end else if (pat == 2) begin
      f[0] = 8'hAA; f[1] = 8'h11;
    end

    if (do_start) begin
      drive(sel, 1'b1, 1'b0, 16'h0000);
      tick();
      drive(sel, 1'b0, 1'b0, 16'h0000);
      sample(sel, v, d, a, l, b, dn);
      checks++;
      if (v !== 1'b0 || b !== 1'b1 || dn !== 1'b0)
        $display("FAIL start dut%0d: valid=%b busy=%b done=%b, need 0 1 0", sel, v, b, dn);
    end

    for (int k = 0; k < nrun; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(sel, 1'b0, 1'b0, 16'($urandom));
        tick();
        sample(sel, v, d, a, l, b, dn);
        checks++;
        if (v !== 1'b0 || dn !== 1'b0 || b !== 1'b1 || d !== hold_data[sel] ||
            a !== hold_addr[sel] || l !== hold_last[sel]) begin
          errors++;
          $display("FAIL gap dut%0d word %0d: v=%b dn=%b b=%b d=%h a=%0d l=%b, need 0 0 1 %h %0d %b",
                   sel, k, v, dn, b, d, a, l, hold_data[sel], hold_addr[sel], hold_last[sel]);
        end
      end
      drive(sel, 1'b0, 1'b1, {f[2*k], f[2*k+1]});
      tick();
      drive(sel, 1'b0, 1'b0, 16'h0000);

      exp_v  = 1'b0;
      exp_dn = 1'b0;
      exp_l  = 1'b0;
      exp_d  = '0;
      exp_a  = '0;
      for (int j = 0; j < 2; j++) begin
        p = 2 * k + j;
        if (p >= hdr && p < total) begin
          rel = p - hdr;
          r   = rel / stride;
          c   = rel % stride;
          if (c < 3 * w && c % 3 == 2) begin
            x     = c / 3;
            exp_v = 1'b1;
            exp_a = AW'((h - 1 - r) * w + x);
            exp_d = {f[p][7:3], f[p-1][7:2], f[p-2][7:3]};
            exp_l = (r == h - 1) && (x == w - 1);
          end
        end
        if (p == total - 1) exp_dn = 1'b1;
      end
      exp_b = (2 * k + 1 < total - 1);
      if (exp_v) begin
        hold_data[sel] = exp_d;
        hold_addr[sel] = exp_a;
        hold_last[sel] = exp_l;
      end

      sample(sel, v, d, a, l, b, dn);
      if (v === 1'b1) begin
        if (n_pix == 0) begin pix0 = d; addr0 = a; end
        if (n_pix == 1) pix1 = d;
        n_pix++;
      end
      if (dn === 1'b1) n_done++;
      checks++;
      if (v !== exp_v) begin
        errors++;
        $display("FAIL pix_valid dut%0d word %0d: got %b need %b", sel, k, v, exp_v);
      end
      checks++;
      if (d !== hold_data[sel] || a !== hold_addr[sel] || l !== hold_last[sel]) begin
        errors++;
        $display("FAIL pixel dut%0d word %0d: data=%h addr=%0d last=%b need %h %0d %b",
                 sel, k, d, a, l, hold_data[sel], hold_addr[sel], hold_last[sel]);
      end
      checks++;
      if (dn !== exp_dn || b !== exp_b) begin
        errors++;
        $display("FAIL status dut%0d word %0d: done=%b busy=%b need %b %b",
                 sel, k, dn, b, exp_dn, exp_b);
      end
    end

    if (nrun == nwords) begin
      for (int k = 0; k < 5; k++) begin
        drive(sel, 1'b0, 1'b1, 16'($urandom));
        tick();
        drive(sel, 1'b0, 1'b0, 16'h0000);
        sample(sel, v, d, a, l, b, dn);
        if (dn === 1'b1) n_done++;
        checks++;
        if (v !== 1'b0 || dn !== 1'b0 || b !== 1'b0 || d !== hold_data[sel] ||
            a !== hold_addr[sel] || l !== hold_last[sel]) begin
          errors++;
          $display("FAIL trailing dut%0d word %0d: v=%b dn=%b b=%b d=%h a=%0d, need 0 0 0 %h %0d",
                   sel, k, v, dn, b, d, a, hold_data[sel], hold_addr[sel]);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic v, l, b, dn;
    logic [15:0] d;
    logic [AW-1:0] a;
    rst = '1;
    for (int s = 0; s < NDUT; s++) drive(s, 1'b1, 1'b1, 16'($urandom));
    tick();
    tick();
    rst = '0;
    for (int s = 0; s < NDUT; s++) begin
      drive(s, 1'b0, 1'b0, 16'h0000);
      hold_data[s] = '0;
      hold_addr[s] = '0;
      hold_last[s] = 1'b0;
      sample(s, v, d, a, l, b, dn);
      checks++;
      if ({v, d, a, l, b, dn} !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: v=%b d=%h a=%0d l=%b b=%b dn=%b, need all 0",
                 s, v, d, a, l, b, dn);
      end
    end
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < NDUT; s++) drive(s, 1'b0, 1'b1, 16'($urandom));
      tick();
      for (int s = 0; s < NDUT; s++) begin
        drive(s, 1'b0, 1'b0, 16'h0000);
        sample(s, v, d, a, l, b, dn);
        checks++;
        if (v !== 1'b0 || b !== 1'b0 || dn !== 1'b0) begin
          errors++;
          $display("FAIL idle_ignore dut%0d: v=%b b=%b dn=%b, need 0 0 0", s, v, b, dn);
        end
      end
    end
  endtask

  task automatic test_raster_colour();
    int np, nd;
    logic [15:0] p0, p1;
    logic [AW-1:0] a0;
    run_frame(0, 1'b1, 0, 1000, np, nd, p0, p1, a0);
    checks++;
    if (np != 4 || nd != 1 || a0 !== AW'(2)) begin
      errors++;
      $display("FAIL raster: pixels=%0d dones=%0d addr0=%0d, need 4 1 2", np, nd, a0);
    end
    run_frame(0, 1'b1, 1, 1000, np, nd, p0, p1, a0);
    checks++;
    if (p0 !== 16'h801F || p1 !== 16'hFFFF) begin
      errors++;
      $display("FAIL colour: pix0=%h pix1=%h, need 801f ffff", p0, p1);
    end
  endtask

  task automatic test_odd_pad_header();
    int np, nd;
    logic [15:0] p0, p1;
    logic [AW-1:0] a0;
    run_frame(1, 1'b1, 0, 1000, np, nd, p0, p1, a0);
    checks++;
    if (np != 3 || nd != 1 || a0 !== AW'(2)) begin
      errors++;
      $display("FAIL odd_pad: pixels=%0d dones=%0d addr0=%0d, need 3 1 2", np, nd, a0);
    end
    run_frame(2, 1'b1, 2, 1000, np, nd, p0, p1, a0);
    checks++;
    if (np != 2 || nd != 1 || p0[4:0] !== 5'h02) begin
      errors++;
      $display("FAIL odd_header: pixels=%0d dones=%0d blue0=%h, need 2 1 02", np, nd, p0[4:0]);
    end
    run_frame(3, 1'b1, 0, 1000, np, nd, p0, p1, a0);
    checks++;
    if (np != 8 || nd != 1 || a0 !== AW'(4)) begin
      errors++;
      $display("FAIL no_pad: pixels=%0d dones=%0d addr0=%0d, need 8 1 4", np, nd, a0);
    end
  endtask

  task automatic test_restart();
    int np, nd;
    logic [15:0] p0, p1, d;
    logic [AW-1:0] a0, a;
    logic v, l, b, dn;
    run_frame(4, 1'b1, 0, 43, np, nd, p0, p1, a0);
    checks++;
    if (np != 10 || nd != 0) begin
      errors++;
      $display("FAIL partial: pixels=%0d dones=%0d, need 10 0", np, nd);
    end
    // start together with a word: the word must be dropped
    drive(4, 1'b1, 1'b1, 16'($urandom));
    tick();
    drive(4, 1'b0, 1'b0, 16'h0000);
    sample(4, v, d, a, l, b, dn);
    checks++;
    if (v !== 1'b0 || b !== 1'b1 || dn !== 1'b0) begin
      errors++;
      $display("FAIL restart: v=%b b=%b dn=%b, need 0 1 0", v, b, dn);
    end
    run_frame(4, 1'b0, 0, 1000, np, nd, p0, p1, a0);
    checks++;
    if (np != 15 || nd != 1 || a0 !== AW'(10)) begin
      errors++;
      $display("FAIL after_restart: pixels=%0d dones=%0d addr0=%0d, need 15 1 10", np, nd, a0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int np, nd;
    logic [15:0] p0, p1, d;
    logic [AW-1:0] a0, a;
    logic v, l, b, dn;
    run_frame(4, 1'b1, 0, 30, np, nd, p0, p1, a0);
    rst[4] = 1'b1;
    drive(4, 1'b1, 1'b1, 16'($urandom));
    tick();
    rst[4] = 1'b0;
    drive(4, 1'b0, 1'b0, 16'h0000);
    hold_data[4] = '0;
    hold_addr[4] = '0;
    hold_last[4] = 1'b0;
    sample(4, v, d, a, l, b, dn);
    checks++;
    if ({v, d, a, l, b, dn} !== '0) begin
      errors++;
      $display("FAIL mid_reset: v=%b d=%h a=%0d l=%b b=%b dn=%b, need all 0", v, d, a, l, b, dn);
    end
    for (int k = 0; k < 4; k++) begin
      drive(4, 1'b0, 1'b1, 16'($urandom));
      tick();
      drive(4, 1'b0, 1'b0, 16'h0000);
      sample(4, v, d, a, l, b, dn);
      checks++;
      if ({v, d, a, l, b, dn} !== '0) begin
        errors++;
        $display("FAIL post_reset_ignore word %0d: v=%b d=%h a=%0d b=%b dn=%b, need all 0",
                 k, v, d, a, b, dn);
      end
    end
    run_frame(4, 1'b1, 0, 1000, np, nd, p0, p1, a0);
    checks++;
    if (np != 15 || nd != 1) begin
      errors++;
      $display("FAIL after_reset_frame: pixels=%0d dones=%0d, need 15 1", np, nd);
    end
  endtask

  task automatic test_back_to_back();
    int np, nd, s;
    logic [15:0] p0, p1;
    logic [AW-1:0] a0;
    for (int it = 0; it < 6; it++) begin
      s = $urandom_range(0, NDUT - 1);
      run_frame(s, 1'b1, 0, 1000, np, nd, p0, p1, a0);
      checks++;
      if (np != cfg_w(s) * cfg_h(s) || nd != 1) begin
        errors++;
        $display("FAIL back_to_back dut%0d: pixels=%0d dones=%0d, need %0d 1",
                 s, np, nd, cfg_w(s) * cfg_h(s));
      end
    end
  endtask

  initial begin
    rst = '1;
    for (int s = 0; s < NDUT; s++) drive(s, 1'b0, 1'b0, 16'h0000);
    test_reset();
    test_raster_colour();
    test_odd_pad_header();
    test_restart();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
